// File: rtl/ram_sp_clr_pkg.sv
// Shared types and constants for the single-port RAM with bulk clear.
// Holds the clear-engine state encoding and the read-during-write mode selectors.
package ram_sp_clr_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear engine: walks the whole array once, writing one zero word per cycle.
// busy covers exactly 2**ADDR_W cycles; a new clr_req while busy is ignored.
module ram_clr_ctrl
   import ram_sp_clr_pkg::*;
#(
   parameter int ADDR_W = 11
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   clr_state_t        state_q;
   clr_state_t        state_d;
   logic [ADDR_W-1:0] cnt_q;
   logic              last_addr;

   // The counter wraps back to zero by itself, so no extra bit is needed.
   assign last_addr = &cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // NOTE: next-state defaults to the current state before the case so no
   // path leaves state_d unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (clr_req)   state_d = CLEAR;
         CLEAR: if (last_addr) state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   assign busy     = (state_q == CLEAR);
   assign clr_we   = busy;
   assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port byte-lane RAM with registered read and a whole-array clear engine.
// Define RAM_SP_CLR_OUT_REG_EN to add a second output register (read latency 2).
module ram_sp_clr
   import ram_sp_clr_pkg::*;
#(
   parameter int DATA_W   = 8,   // must be a multiple of 8
   parameter int ADDR_W   = 11,
   parameter int RDW_MODE = RDW_READ_FIRST
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   input  logic [ADDR_W-1:0]   ADDRESS,
   input  logic                WE,
   input  logic [DATA_W/8-1:0] BE,
   input  logic [DATA_W-1:0]   DI,
   input  logic                CLR,
   output logic [DATA_W-1:0]   DO,
   output logic                VALID,
   output logic                BUSY
);

   localparam int LANES = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              accept;
   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] merged_word;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] do_s1;
   logic              valid_s1;

   ram_clr_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_clr_ctrl (
      .CLK      (CLK),
      .RST      (RST),
      .clr_req  (CLR),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // A clear request in the same cycle takes priority and drops the access.
   assign accept = EN & ~busy & ~CLR;

   always_comb begin
      old_word    = mem[ADDRESS];
      merged_word = old_word;
      for (int i = 0; i < LANES; i++) begin
         if (BE[i]) merged_word[8*i +: 8] = DI[8*i +: 8];
      end
   end

   // With BE all-zero the merged word equals the old word, so WE alone selects.
   assign rd_word = (RDW_MODE == RDW_WRITE_FIRST && WE) ? merged_word : old_word;

   // NOTE: the array has no reset so it maps onto block RAM; contents survive
   // RST and an interrupted clear is simply left partial.
   always_ff @(posedge CLK) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (accept && WE) begin
         for (int i = 0; i < LANES; i++) begin
            if (BE[i]) mem[ADDRESS][8*i +: 8] <= DI[8*i +: 8];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         do_s1    <= '0;
         valid_s1 <= 1'b0;
      end else begin
         valid_s1 <= accept;
         if (accept) do_s1 <= rd_word;
      end
   end

`ifdef RAM_SP_CLR_OUT_REG_EN
   logic [DATA_W-1:0] do_s2;
   logic              valid_s2;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         do_s2    <= '0;
         valid_s2 <= 1'b0;
      end else begin
         do_s2    <= do_s1;
         valid_s2 <= valid_s1;
      end
   end

   assign DO    = do_s2;
   assign VALID = valid_s2;
`else
   assign DO    = do_s1;
   assign VALID = valid_s1;
`endif

   assign BUSY = busy;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed bench for ram_sp_clr (DATA_W=16, ADDR_W=4): one read-first and one
// write-first instance share stimulus; latency follows RAM_SP_CLR_OUT_REG_EN.
module tb_ram_sp_clr;

   localparam int DW = 16;
   localparam int AW = 4;
`ifdef RAM_SP_CLR_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          CLK = 1'b0;
   logic          RST;
   logic          EN;
   logic          WE;
   logic          CLR;
   logic [1:0]    BE;
   logic [AW-1:0] ADDRESS;
   logic [DW-1:0] DI;
   logic [DW-1:0] do_rf, do_wf;
   logic          valid_rf, valid_wf;
   logic          busy_rf, busy_wf;

   int checks = 0;
   int errors = 0;

   ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0)) u_rf (
      .CLK(CLK), .RST(RST), .EN(EN), .ADDRESS(ADDRESS), .WE(WE), .BE(BE),
      .DI(DI), .CLR(CLR), .DO(do_rf), .VALID(valid_rf), .BUSY(busy_rf)
   );

   ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1)) u_wf (
      .CLK(CLK), .RST(RST), .EN(EN), .ADDRESS(ADDRESS), .WE(WE), .BE(BE),
      .DI(DI), .CLR(CLR), .DO(do_wf), .VALID(valid_wf), .BUSY(busy_wf)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic          en;
      logic          we;
      logic [1:0]    be;
      logic [AW-1:0] addr;
      logic [DW-1:0] di;
      logic          chk_do;
      logic [DW-1:0] exp_rf;
      logic [DW-1:0] exp_wf;
      logic          exp_valid;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic en, input logic we, input logic [1:0] be,
                        input logic [AW-1:0] addr, input logic [DW-1:0] di, input logic clr);
      EN = en; WE = we; BE = be; ADDRESS = addr; DI = di; CLR = clr;
   endtask

   // Present one cycle of inputs, then idle until the result reaches the outputs.
   task automatic access(input logic en, input logic we, input logic [1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] di);
      drive(en, we, be, addr, di, 1'b0);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      if (LAT == 2) tick();
   endtask

   task automatic fill_ones();
      for (int a = 0; a < 16; a++) access(1'b1, 1'b1, 2'b11, AW'(a), 16'hFFFF);
      access(1'b1, 1'b0, 2'b00, 4'd15, 16'h0000);
      check("fill readback @15", do_rf, 16'hFFFF);
   endtask

   initial begin
      int busy_cycles;

      vecs[0]  = '{1'b1, 1'b1, 2'b11, 4'd3, 16'hABCD, 1'b0, 16'h0000, 16'h0000, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b1, 16'hABCD, 16'hABCD, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 2'b01, 4'd3, 16'h1234, 1'b1, 16'hABCD, 16'hAB34, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b1, 16'hAB34, 16'hAB34, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 2'b11, 4'd5, 16'h5A5A, 1'b0, 16'h0000, 16'h0000, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 2'b00, 4'd5, 16'hFFFF, 1'b1, 16'h5A5A, 16'h5A5A, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b1, 16'h5A5A, 16'h5A5A, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 2'b10, 4'd5, 16'h00C3, 1'b1, 16'h5A5A, 16'h005A, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b1, 16'h005A, 16'h005A, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 2'b11, 4'd5, 16'h1111, 1'b1, 16'h005A, 16'h005A, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b1, 16'h005A, 16'h005A, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b1, 16'h005A, 16'h005A, 1'b0};

      RST = 1'b1;
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      tick();
      tick();
      check("reset DO", do_rf, 16'h0000);
      check("reset VALID", valid_rf, 1'b0);
      check("reset BUSY", busy_rf, 1'b0);
      RST = 1'b0;

      // First vector lands on the first edge after reset release.
      for (int i = 0; i < 12; i++) begin
         access(vecs[i].en, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].di);
         if (vecs[i].chk_do) begin
            check($sformatf("vec%0d DO rd-first", i), do_rf, vecs[i].exp_rf);
            check($sformatf("vec%0d DO wr-first", i), do_wf, vecs[i].exp_wf);
         end
         check($sformatf("vec%0d VALID rd-first", i), valid_rf, vecs[i].exp_valid);
         check($sformatf("vec%0d VALID wr-first", i), valid_wf, vecs[i].exp_valid);
      end

      // Full clear: CLR collides with an access, a second CLR arrives mid-clear,
      // reads are presented throughout and must be ignored.
      fill_ones();
      drive(1'b1, 1'b1, 2'b11, 4'd0, 16'h1234, 1'b1);
      tick();
      busy_cycles = 0;
      for (int k = 0; k < 40; k++) begin
         if (!busy_rf) break;
         busy_cycles++;
         check("VALID during clear", valid_rf, 1'b0);
         drive(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000, busy_cycles == 10);
         tick();
      end
      check("BUSY cycle count", busy_cycles, 16);
      check("VALID as BUSY falls", valid_rf, 1'b0);
      // The access presented in the cycle BUSY falls is accepted.
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      if (LAT == 2) tick();
      check("read at BUSY fall VALID", valid_rf, 1'b1);
      check("read at BUSY fall DO", do_rf, 16'h0000);
      for (int a = 0; a < 16; a++) begin
         access(1'b1, 1'b0, 2'b00, AW'(a), 16'h0000);
         check($sformatf("cleared @%0d rd-first", a), do_rf, 16'h0000);
         check($sformatf("cleared @%0d wr-first", a), do_wf, 16'h0000);
      end

      // Reset during clear: outputs drop at once, clear does not resume.
      fill_ones();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      repeat (5) tick();
      check("BUSY before mid-clear reset", busy_rf, 1'b1);
      RST = 1'b1;
      #1;
      check("async reset BUSY", busy_rf, 1'b0);
      check("async reset VALID", valid_rf, 1'b0);
      check("async reset DO", do_rf, 16'h0000);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      tick();
      check("BUSY after reset release", busy_rf, 1'b0);
      for (int a = 0; a < 16; a++) begin
         if (a >= 5 && a <= 7) continue;
         access(1'b1, 1'b0, 2'b00, AW'(a), 16'h0000);
         check($sformatf("partial clear @%0d", a), do_rf, (a < 5) ? 16'h0000 : 16'hFFFF);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/ram_sp_clr.md
RAM_SP_CLR -- requirements
Module: ram_sp_clr

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 11, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter RDW_MODE, default 0, read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new data).
REQ-004 SHALL have port CLK  in  1  clock; one clock domain, all logic on rising edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port EN  in  1  access enable.
REQ-007 SHALL have port ADDRESS  in  ADDR_W  access address.
REQ-008 SHALL have port WE  in  1  write enable, qualified by EN.
REQ-009 SHALL have port BE  in  DATA_W/8  byte-lane write enables, bit i covers DI[8i+7:8i].
REQ-010 SHALL have port DI  in  DATA_W  write data.
REQ-011 SHALL have port CLR  in  1  single-cycle request to zero the whole array.
REQ-012 SHALL have port DO  out  DATA_W  registered read data.
REQ-013 SHALL have port VALID  out  1  DO holds data of an accepted access.
REQ-014 SHALL have port BUSY  out  1  clear engine active; user accesses ignored.

Function
REQ-015 Access accepted when EN=1 and FSM in IDLE and CLR=0; every accepted access is also a read of ADDRESS.
REQ-016 Accepted write updates only lanes with BE[i]=1; WE=1 with BE all-zero modifies nothing but still reads.
REQ-017 Read latency 1 cycle: DO/VALID update on the edge after acceptance; VALID=0 on edges following cycles with no accepted access, DO holds last value.
REQ-018 Write to same address as read in same cycle: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns merged post-write word (unwritten lanes old).
REQ-019 FSM states IDLE, CLEAR; IDLE->CLEAR when CLR=1; CLEAR->IDLE after writing address 2**ADDR_W-1.
REQ-020 In CLEAR, one word per cycle written with zero, counter 0 upward; clear takes exactly 2**ADDR_W cycles; BUSY=1 for exactly those cycles, starting on the edge after CLR is sampled.
REQ-021 CLR with EN in same IDLE cycle: clear wins, access dropped, VALID=0 next cycle.
REQ-022 CLR during CLEAR ignored (no restart); EN during CLEAR ignored, VALID=0.
REQ-023 Counter wraps naturally at ADDR_W bits; last-address detect uses all-ones compare, no extra bit.
REQ-024 Access accepted on the cycle BUSY falls sees fully cleared array.

Reset
REQ-025 RST asserted asynchronously forces FSM=IDLE, counter=0, DO=0, VALID=0, BUSY=0.
REQ-026 Array contents SHALL NOT be reset; reset mid-clear leaves array partially cleared, clear not resumed.
REQ-027 First access SHALL be accepted on the first rising edge after RST deasserts.

Configuration
REQ-028 Macro RAM_SP_CLR_OUT_REG_EN defined: extra output register stage on DO and VALID, read latency 2, both reset to 0.
REQ-029 Macro undefined: single stage, latency 1 per REQ-017; BUSY timing identical in both builds.

Structure
REQ-030 Shared package SHALL hold FSM state typedef (IDLE, CLEAR) and RDW_MODE constants (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1).
REQ-031 Clear engine (FSM + counter + BUSY) SHALL be sub-module ram_clr_ctrl; array, lane merge and output stages stay in ram_sp_clr.

Verification (DATA_W=16, ADDR_W=4, macro undefined unless stated)
REQ-032 Write 0xABCD @3, BE=11, then read @3 -> DO=0xABCD, VALID=1 one cycle after read.
REQ-033 With @3=0xABCD, write 0x1234 BE=01 while reading @3 -> RDW_MODE=0: DO=0xABCD; RDW_MODE=1: DO=0xAB34; later read -> 0xAB34.
REQ-034 Fill all 16 words 0xFFFF, pulse CLR with EN=1 -> BUSY high exactly 16 cycles, VALID=0 throughout, all reads afterwards return 0x0000.
REQ-035 Assert RST at clear cycle 5 -> BUSY/VALID/DO=0 immediately; words 0..4 read 0x0000, words 8..15 read 0xFFFF.
REQ-036 Second CLR pulse at clear cycle 10 -> BUSY still falls after cycle 16 total.
REQ-037 Macro defined: read @3 -> DO/VALID appear two cycles after acceptance.
